// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the blocks it releases.
// The sequencer side uses the master modport; the system/testbench side uses slave.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    localparam int ERR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic                   sw_reset_req;
    logic [NUM_DOMAINS-1:0] domain_ack;
    logic [NUM_DOMAINS-1:0] domain_reset_n;
    logic                   seq_busy;
    logic                   seq_done;
    logic                   seq_error;
    logic [ERR_W-1:0]       err_domain;

    modport master (
        input  sw_reset_req,
        input  domain_ack,
        output domain_reset_n,
        output seq_busy,
        output seq_done,
        output seq_error,
        output err_domain
    );

    modport slave (
        output sw_reset_req,
        output domain_ack,
        input  domain_reset_n,
        input  seq_busy,
        input  seq_done,
        input  seq_error,
        input  err_domain
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases downstream domain resets one at a time, waiting for each domain's
// acknowledge (bounded by a timeout) and a fixed gap before the next release.
// A software restart request re-runs the whole sequence from the initial hold.
// NUM_DOMAINS must match the parameter of the connected interface instance.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clock,
    input  logic               sync_reset_n,
    reset_sequencer_if.master  bus
);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        HOLD,
        WAIT_ACK,
        GAP,
        DONE,
        ERROR
    } state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       idx, idx_next, idx_inc;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [NUM_DOMAINS-1:0] rel, rel_next;
    logic                   busy, busy_next;
    logic                   done, done_next;
    logic                   error, error_next;
    logic [IDX_W-1:0]       err_dom, err_dom_next;

    // State register plus every registered output; reset forces the start of a fresh sequence.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            state   <= HOLD;
            idx     <= '0;
            cnt     <= '0;
            rel     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
            err_dom <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            cnt     <= cnt_next;
            rel     <= rel_next;
            busy    <= busy_next;
            done    <= done_next;
            error   <= error_next;
            err_dom <= err_dom_next;
        end
    end

    // Next-state logic: a software restart overrides everything, otherwise step the sequence.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        cnt_next     = cnt;
        rel_next     = rel;
        busy_next    = busy;
        done_next    = done;
        error_next   = error;
        err_dom_next = err_dom;
        idx_inc      = idx + IDX_W'(1);

        if (bus.sw_reset_req) begin
            state_next   = HOLD;
            idx_next     = '0;
            cnt_next     = '0;
            rel_next     = '0;
            busy_next    = 1'b1;
            done_next    = 1'b0;
            error_next   = 1'b0;
            err_dom_next = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == GAP_LAST) begin
                        rel_next[0] = 1'b1;
                        cnt_next    = '0;
                        state_next  = WAIT_ACK;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                WAIT_ACK: begin
                    if (bus.domain_ack[idx]) begin
                        if (idx == LAST_IDX) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end else begin
                            state_next = GAP;
                            cnt_next   = '0;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_next   = ERROR;
                        error_next   = 1'b1;
                        err_dom_next = idx;
                        rel_next     = '0;
                        busy_next    = 1'b0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        idx_next          = idx_inc;
                        rel_next[idx_inc] = 1'b1;
                        cnt_next          = '0;
                        state_next        = WAIT_ACK;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.domain_reset_n = rel;
    assign bus.seq_busy       = busy;
    assign bus.seq_done       = done;
    assign bus.seq_error      = error;
    assign bus.err_domain     = err_dom;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: fixed-edge vector table, hand-written
// corner sequences, and a randomized run compared against a counting model.
module tb_reset_sequencer;
    localparam int N       = 4;
    localparam int GAP     = 8;
    localparam int TIMEOUT = 64;

    typedef struct {
        int         mode;
        logic [3:0] mask;
        int         edge_at;
        logic [8:0] exp_out;
    } vec_t;

    logic clock;
    logic sync_reset_n;

    reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();

    reset_sequencer #(
        .NUM_DOMAINS(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .sync_reset_n(sync_reset_n),
        .bus(bus)
    );

    int         errors = 0;
    int         checks = 0;
    int         edge_no = 0;
    int         ack_mode = 0;
    int         ack_pct = 50;
    logic [3:0] ack_mask = 4'b1111;
    logic [3:0] d1 = 4'b0000;
    logic [3:0] d2 = 4'b0000;

    int m_now = 0;
    int m_rel = 0;
    int m_acked = 0;
    int m_last = 0;
    int m_err_dom = 0;
    bit m_err = 1'b0;

    vec_t vecs[17];

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t make_vec(input int mode, input logic [3:0] mask, input int e,
                                      input logic [8:0] exp_out);
        vec_t v;
        v.mode    = mode;
        v.mask    = mask;
        v.edge_at = e;
        v.exp_out = exp_out;
        return v;
    endfunction

    // Reference model in terms of domains released/acknowledged and edges since the last event.
    function automatic void model_edge(input logic rst_n, input logic sw, input logic [3:0] ack);
        m_now++;
        if (!rst_n || sw) begin
            m_rel     = 0;
            m_acked   = 0;
            m_err     = 1'b0;
            m_err_dom = 0;
            m_last    = m_now;
        end else if (m_err || m_acked == N) begin
        end else if (m_rel == m_acked) begin
            if (m_now - m_last == GAP) begin
                m_rel++;
                m_last = m_now;
            end
        end else if (ack[m_acked]) begin
            m_acked++;
            m_last = m_now;
        end else if (m_now - m_last == TIMEOUT) begin
            m_err     = 1'b1;
            m_err_dom = m_acked;
        end
    endfunction

    function automatic logic [8:0] model_outputs();
        logic [3:0] r;
        r = m_err ? 4'b0000 : 4'((1 << m_rel) - 1);
        return {r, (!m_err && m_acked < N), (m_acked == N), m_err, 2'(m_err_dom)};
    endfunction

    function automatic logic [8:0] dut_outputs();
        return {bus.domain_reset_n, bus.seq_busy, bus.seq_done, bus.seq_error, bus.err_domain};
    endfunction

    task automatic check_output(input string name, input logic [8:0] exp_out);
        logic [8:0] act;
        act = dut_outputs();
        checks++;
        if (act !== exp_out) begin
            errors++;
            $display("[TB] FAIL %s edge %0d: got rst_n=%b busy=%b done=%b err=%b dom=%0d, want rst_n=%b busy=%b done=%b err=%b dom=%0d",
                     name, edge_no, act[8:5], act[4], act[3], act[2], act[1:0],
                     exp_out[8:5], exp_out[4], exp_out[3], exp_out[2], exp_out[1:0]);
        end
    endtask

    // One clock: model follows the sampled inputs, outputs are checked 1ns after the edge,
    // then the acknowledge stimulus for the next edge is prepared.
    task automatic apply_stimulus();
        logic [3:0] a;
        @(posedge clock);
        model_edge(sync_reset_n, bus.sw_reset_req, bus.domain_ack);
        #1;
        if (!sync_reset_n) edge_no = 0;
        else edge_no++;
        check_output("model", model_outputs());
        case (ack_mode)
            0: begin
                bus.domain_ack = ack_mask & d2;
                d2 = d1;
                d1 = bus.domain_reset_n;
            end
            1: bus.domain_ack = ack_mask;
            3: begin
                a = 4'b0000;
                for (int b = 0; b < N; b++) a[b] = ($urandom_range(0, 99) < ack_pct);
                bus.domain_ack = a;
            end
            default: begin
            end
        endcase
    endtask

    task automatic reset_dut(input int mode, input logic [3:0] mask);
        ack_mode = mode;
        ack_mask = mask;
        d1 = 4'b0000;
        d2 = 4'b0000;
        bus.domain_ack = (mode == 1) ? mask : 4'b0000;
        bus.sw_reset_req = 1'b0;
        sync_reset_n = 1'b0;
        apply_stimulus();
        sync_reset_n = 1'b1;
    endtask

    task automatic run_to(input int mode, input logic [3:0] mask, input int e);
        reset_dut(mode, mask);
        while (edge_no < e) apply_stimulus();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        sync_reset_n = 1'b0;
        bus.sw_reset_req = 1'b0;
        bus.domain_ack = 4'b0000;

        vecs[0]  = make_vec(0, 4'b1111, 7,  {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[1]  = make_vec(0, 4'b1111, 8,  {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[2]  = make_vec(0, 4'b1111, 18, {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[3]  = make_vec(0, 4'b1111, 19, {4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[4]  = make_vec(0, 4'b1111, 30, {4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[5]  = make_vec(0, 4'b1111, 41, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[6]  = make_vec(0, 4'b1111, 43, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[7]  = make_vec(0, 4'b1111, 44, {4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs[8]  = make_vec(0, 4'b1011, 30, {4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[9]  = make_vec(0, 4'b1011, 93, {4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[10] = make_vec(0, 4'b1011, 94, {4'b0000, 1'b0, 1'b0, 1'b1, 2'd2});
        vecs[11] = make_vec(1, 4'b1111, 8,  {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[12] = make_vec(1, 4'b1111, 16, {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[13] = make_vec(1, 4'b1111, 17, {4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[14] = make_vec(1, 4'b1111, 26, {4'b0111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[15] = make_vec(1, 4'b1111, 35, {4'b1111, 1'b1, 1'b0, 1'b0, 2'd0});
        vecs[16] = make_vec(1, 4'b1111, 36, {4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});

        for (int i = 0; i < 17; i++) begin
            run_to(vecs[i].mode, vecs[i].mask, vecs[i].edge_at);
            check_output($sformatf("vec%0d", i), vecs[i].exp_out);
        end

        // Ack arrives on exactly the timeout edge: ack must win.
        reset_dut(2, 4'b0000);
        while (edge_no < 71) apply_stimulus();
        bus.domain_ack = 4'b0001;
        apply_stimulus();
        check_output("tie_ack_wins", {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        while (edge_no < 79) apply_stimulus();
        check_output("tie_gap_hold", {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        apply_stimulus();
        check_output("tie_release1", {4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});

        // Software restart out of ERROR.
        run_to(0, 4'b1011, 94);
        check_output("in_error", {4'b0000, 1'b0, 1'b0, 1'b1, 2'd2});
        bus.sw_reset_req = 1'b1;
        apply_stimulus();
        bus.sw_reset_req = 1'b0;
        check_output("restart_clear", {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        for (int k = 0; k < 7; k++) apply_stimulus();
        check_output("restart_hold", {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
        apply_stimulus();
        check_output("restart_release0", {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});

        // Mid-sequence disturbance at E25, first by sync reset then by software request.
        for (int pass = 0; pass < 2; pass++) begin
            run_to(0, 4'b1111, 24);
            check_output("pre_disturb", {4'b0011, 1'b1, 1'b0, 1'b0, 2'd0});
            if (pass == 0) sync_reset_n = 1'b0;
            else bus.sw_reset_req = 1'b1;
            apply_stimulus();
            sync_reset_n = 1'b1;
            bus.sw_reset_req = 1'b0;
            check_output("disturb_clear", {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
            for (int k = 0; k < 7; k++) apply_stimulus();
            check_output("disturb_hold", {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0});
            apply_stimulus();
            check_output("disturb_release0", {4'b0001, 1'b1, 1'b0, 1'b0, 2'd0});
        end

        // Stray acknowledge activity once DONE must change nothing.
        run_to(1, 4'b1111, 36);
        ack_mode = 3;
        ack_pct = 50;
        for (int k = 0; k < 12; k++) apply_stimulus();
        check_output("done_stable", {4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});

        // Randomized acks, restarts and resets checked cycle by cycle against the model.
        reset_dut(3, 4'b1111);
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: ack_pct = 50;
                1: ack_pct = 3;
                2: ack_pct = 0;
                3: ack_pct = 20;
                4: ack_pct = 1;
                default: ack_pct = 100;
            endcase
            for (int k = 0; k < 400; k++) begin
                int r;
                r = $urandom_range(0, 999);
                bus.sw_reset_req = (r < 4) || (r == 9);
                sync_reset_n = !((r >= 6) && (r <= 9));
                apply_stimulus();
            end
        end
        bus.sw_reset_req = 1'b0;
        sync_reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the testbench/system synchronous reset and releases a set of downstream domain resets one at a time in a fixed order. Each release waits for that domain's acknowledge, bounded by a timeout, before the next domain is released. It sits directly downstream of the clock/reset generator and drives the reset inputs of every functional block. A software restart request re-runs the whole sequence without asserting the system reset.

## Interface
- NUM_DOMAINS, 4, number of reset domains; legal range 1..16.
- GAP_CYCLES, 8, cycles of initial hold and of inter-domain gap; must be ≥1.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for a domain acknowledge; must be ≥1.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- sync_reset_n  in  1  synchronous, active-low reset; sampled only on the rising edge of clock.
- sw_reset_req  in  1  one-cycle request to restart the sequence.
- domain_ack  in  NUM_DOMAINS  per-domain "out of reset" acknowledge; level, sampled each edge.
- domain_reset_n  out  NUM_DOMAINS  per-domain active-low reset; registered.
- seq_busy  out  1  sequence in progress; registered.
- seq_done  out  1  all domains released and acknowledged; registered.
- seq_error  out  1  acknowledge timeout occurred; registered.
- err_domain  out  max(1,$clog2(NUM_DOMAINS))  index of the domain that timed out; registered.

## Operation
- States: HOLD, WAIT_ACK, GAP, DONE, ERROR. Internal state is a domain index `idx` and a cycle counter `cnt` of width $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES))+1.
- Reset (sync_reset_n==0 at an edge):
  - State goes to HOLD; idx=0, cnt=0.
  - domain_reset_n=all 0, seq_busy=1, seq_done=0, seq_error=0, err_domain=0.
- HOLD:
  - If cnt==GAP_CYCLES-1: set domain_reset_n[0]=1, cnt=0, go to WAIT_ACK.
  - Otherwise cnt++.
- WAIT_ACK, checked in priority order:
  - If domain_ack[idx]==1 and idx==NUM_DOMAINS-1: go to DONE; seq_done=1, seq_busy=0.
  - If domain_ack[idx]==1 and idx<NUM_DOMAINS-1: go to GAP, cnt=0.
  - If cnt==TIMEOUT_CYCLES-1: go to ERROR; seq_error=1, err_domain=idx, domain_reset_n=all 0, seq_busy=0.
  - Otherwise cnt++.
- GAP:
  - If cnt==GAP_CYCLES-1: idx++, domain_reset_n[idx+1]=1, cnt=0, go to WAIT_ACK.
  - Otherwise cnt++.
- DONE and ERROR are terminal until sw_reset_req or reset. domain_ack is ignored in both states.
- sw_reset_req==1 in any state:
  - Same effect as reset on the next edge: all domain_reset_n=0, seq_busy=1, done/error/err_domain cleared, idx=0, cnt=0, go to HOLD.
  - Mid-sequence requests restart the sequence; they are not ignored.
- Release is monotonic within one sequence. Once set, a domain_reset_n bit stays 1 until ERROR, sw_reset_req or reset.
- Only domain_ack[idx] is observed. Acks of other domains have no effect.

## Timing
- Edge numbering: E1 is the first rising edge with sync_reset_n==1.
- domain_reset_n[0] rises after edge E(GAP_CYCLES).
- Ack latency:
  - An ack already high at release is accepted on the first edge after the release edge.
  - Minimum release-to-accept is 1 cycle.
- Release spacing: the next domain is released GAP_CYCLES edges after the accepting edge.
- Timeout: ERROR is entered on the TIMEOUT_CYCLES-th edge after the release edge if no ack was sampled.
- Simultaneous ack and timeout on the same edge: ack wins.
- sync_reset_n low takes priority over sw_reset_req. Both low/high together behave as reset.
- Reset mid-sequence: all outputs reach their reset values after the edge sampling sync_reset_n==0; no partial state survives.
- NUM_DOMAINS==1: DONE is entered directly from WAIT_ACK; GAP is never visited.
- No combinational path from any input to any output.

## Test plan
All scenarios use default parameters and edges numbered from E1.
- **Nominal:** domain_ack = domain_reset_n delayed 2 cycles.
  - domain_reset_n[0..3] rise after E8, E19, E30, E41.
  - seq_done=1 and seq_busy=0 after E44; seq_error stays 0.
- **Timeout:** same stimulus, but domain_ack[2] tied to 0.
  - domain_reset_n[2] rises after E30.
  - After E94: seq_error=1, err_domain=2, domain_reset_n=4'b0000, seq_busy=0, seq_done=0.
- **Ack/timeout tie:** domain_ack[0] rises exactly at the sample point of E72 (64th edge after release at E8).
  - State goes to GAP, not ERROR; domain_reset_n[1] rises after E80.
- **Restart after error:** pulse sw_reset_req for one cycle while in ERROR.
  - Next edge: seq_error=0, err_domain=0, seq_busy=1, all domain resets 0.
  - Nominal sequence then repeats with domain_reset_n[0] rising 8 edges later.
- **Mid-sequence disturbance:** assert sync_reset_n=0 for one cycle at E25 (domain 1 released).
  - After E25: all outputs at reset values.
  - domain_reset_n[0] rises 8 edges after reset is released.
  - Same check with sw_reset_req at E25 gives an identical response.
- **Pre-asserted ack and stray acks:** all domain_ack tied to 1 from E1.
  - Releases after E8, E17, E26, E35; seq_done after E36.
  - Toggling domain_ack in DONE leaves all outputs unchanged.
